// File: rtl/prince_round_seq_pkg.sv
// Shared definitions for the PRINCE round sequencer: FSM state encoding
// and the default timing parameters of the masked round datapath.
package prince_round_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FWD  = 3'd2,
        ST_MID  = 3'd3,
        ST_BWD  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int DEF_NUM_FWD     = 5;
    localparam int DEF_CYC_PER_RND = 7;
    localparam int DEF_MID_CYC     = 14;
    localparam int DEF_RND_W       = 4;
    localparam int DEF_CYC_W       = 4;

endpackage

// File: rtl/prince_seq_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count flag that
// compares the registered count against a caller-supplied terminal value.
// Priority: reset, clear, load, enable.
module prince_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/prince_round_seq.sv
// PRINCE round sequencer: walks LOAD, NUM_FWD forward rounds, the middle
// reflection layer, NUM_FWD backward rounds and final whitening, driving
// the datapath mux selects and the round-constant index.
// Optional feature macro: PRINCE_ROUND_SEQ_PRNG_EN enables the mask PRNG
// advance strobe (prng_step); without it prng_step is tied low.
// All outputs decode registered state/counters only; start never reaches
// an output combinationally.
module prince_round_seq
    import prince_round_seq_pkg::*;
#(
    parameter int NUM_FWD     = DEF_NUM_FWD,
    parameter int CYC_PER_RND = DEF_CYC_PER_RND,
    parameter int MID_CYC     = DEF_MID_CYC,
    parameter int RND_W       = DEF_RND_W,
    parameter int CYC_W       = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [RND_W-1:0] round,
    output logic [CYC_W-1:0] cyc,
    output logic             sel_start,
    output logic             sel_half,
    output logic             sel_end,
    output logic             prng_step
);

    localparam int MAX_CYC = (CYC_PER_RND > MID_CYC) ? CYC_PER_RND : MID_CYC;

    // Reject parameter sets the counters cannot represent.
    if ((NUM_FWD < 1) || (CYC_PER_RND < 1) || (MID_CYC < 1) ||
        ((2 * NUM_FWD + 2) >= (1 << RND_W)) || (MAX_CYC > (1 << CYC_W))) begin : g_param_err
        $error("prince_round_seq: illegal parameter combination");
    end

    localparam logic [CYC_W-1:0] RND_TC       = CYC_W'(CYC_PER_RND - 1);
    localparam logic [CYC_W-1:0] MID_TC       = CYC_W'(MID_CYC - 1);
    localparam logic [RND_W-1:0] RND_LAST_FWD = RND_W'(NUM_FWD);
    localparam logic [RND_W-1:0] RND_LAST_BWD = RND_W'(2 * NUM_FWD + 1);

    state_t           state_q;
    state_t           state_d;
    logic             rnd_clr_s;
    logic             rnd_load_s;
    logic             rnd_en_s;
    logic             cyc_clr_s;
    logic             cyc_en_s;
    logic [RND_W-1:0] rnd_tc_val_s;
    logic [CYC_W-1:0] cyc_tc_val_s;
    logic             rnd_tc_s;
    logic             cyc_tc_s;
    logic [RND_W-1:0] rnd_cnt_s;
    logic [CYC_W-1:0] cyc_cnt_s;

    // Terminal values: the middle layer is longer than a round, and the
    // last round index differs between the forward and backward halves.
    always_comb begin
        cyc_tc_val_s = (state_q == ST_MID) ? MID_TC : RND_TC;
        rnd_tc_val_s = (state_q == ST_BWD) ? RND_LAST_BWD : RND_LAST_FWD;
    end

    // State register; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d    = state_q;
        rnd_clr_s  = 1'b0;
        rnd_load_s = 1'b0;
        rnd_en_s   = 1'b0;
        cyc_clr_s  = 1'b0;
        cyc_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rnd_clr_s = 1'b1;
                cyc_clr_s = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rnd_load_s = 1'b1;
                cyc_clr_s  = 1'b1;
                state_d    = ST_FWD;
            end
            ST_FWD: begin
                if (cyc_tc_s) begin
                    cyc_clr_s = 1'b1;
                    rnd_en_s  = 1'b1;
                    if (rnd_tc_s) begin
                        state_d = ST_MID;
                    end else begin
                        state_d = ST_FWD;
                    end
                end else begin
                    cyc_en_s = 1'b1;
                end
            end
            ST_MID: begin
                if (cyc_tc_s) begin
                    cyc_clr_s = 1'b1;
                    rnd_en_s  = 1'b1;
                    state_d   = ST_BWD;
                end else begin
                    cyc_en_s = 1'b1;
                end
            end
            ST_BWD: begin
                if (cyc_tc_s) begin
                    cyc_clr_s = 1'b1;
                    rnd_en_s  = 1'b1;
                    if (rnd_tc_s) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_BWD;
                    end
                end else begin
                    cyc_en_s = 1'b1;
                end
            end
            ST_FIN: begin
                rnd_clr_s = 1'b1;
                cyc_clr_s = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                rnd_clr_s = 1'b1;
                cyc_clr_s = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    prince_seq_cnt #(.W(RND_W)) u_rnd_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .clr_i      (rnd_clr_s),
        .load_i     (rnd_load_s),
        .load_val_i (RND_W'(1)),
        .en_i       (rnd_en_s),
        .tc_val_i   (rnd_tc_val_s),
        .cnt_o      (rnd_cnt_s),
        .tc_o       (rnd_tc_s)
    );

    prince_seq_cnt #(.W(CYC_W)) u_cyc_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .clr_i      (cyc_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CYC_W{1'b0}}),
        .en_i       (cyc_en_s),
        .tc_val_i   (cyc_tc_val_s),
        .cnt_o      (cyc_cnt_s),
        .tc_o       (cyc_tc_s)
    );

    assign round     = rnd_cnt_s;
    assign cyc       = cyc_cnt_s;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign sel_start = (state_q == ST_LOAD);
    assign sel_half  = (state_q == ST_BWD) || (state_q == ST_FIN);
    assign sel_end   = (state_q == ST_FIN);

`ifdef PRINCE_ROUND_SEQ_PRNG_EN
    // Fresh mask randomness at load and at the first cycle of every layer.
    assign prng_step = (state_q == ST_LOAD) ||
                       (((state_q == ST_FWD) || (state_q == ST_MID) || (state_q == ST_BWD)) &&
                        (cyc_cnt_s == {CYC_W{1'b0}}));
`else
    assign prng_step = 1'b0;
`endif

endmodule

// File: tb/tb_prince_round_seq.sv
// Scoreboard bench for prince_round_seq: stimulus pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
// Vector layout: busy,done,sel_start,sel_half,sel_end,prng_step,round[3:0],cyc[3:0]
module tb_prince_round_seq;

`ifdef PRINCE_ROUND_SEQ_PRNG_EN
    localparam bit PRNG = 1'b1;
`else
    localparam bit PRNG = 1'b0;
`endif

    localparam logic [13:0] FULL  = 14'h3fff;
    localparam logic [13:0] NO_RC = 14'h3f00;
    localparam logic [13:0] NO_C  = 14'h3ff0;

    typedef struct {
        int          t;
        logic [13:0] v;
        logic [13:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, sel_start, sel_half, sel_end, prng_step;
    logic [3:0] round, cyc;
    logic       busy2, done2, sel_start2, sel_half2, sel_end2, prng_step2;
    logic [3:0] round2, cyc2;

    int   tcyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    prince_round_seq dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .round(round), .cyc(cyc), .sel_start(sel_start), .sel_half(sel_half),
        .sel_end(sel_end), .prng_step(prng_step)
    );

    prince_round_seq #(.NUM_FWD(2), .CYC_PER_RND(1), .MID_CYC(1)) dut_small (
        .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2),
        .round(round2), .cyc(cyc2), .sel_start(sel_start2), .sel_half(sel_half2),
        .sel_end(sel_end2), .prng_step(prng_step2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input int t, input logic [13:0] got,
                       input logic [13:0] want, input logic [13:0] mask);
        checks++;
        if ((got & mask) !== (want & mask)) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h mask=%h", name, t, got, want, mask);
        end
    endtask

    // Expected outputs in run cycle k (1..86) for the default parameters.
    function automatic logic [13:0] exp_v(input int k);
        logic b, d, ss, sh, se, pr;
        int   r, c, j;
        b = 1'b1; d = 1'b0; ss = 1'b0; sh = 1'b0; se = 1'b0; pr = 1'b0; r = 0; c = 0;
        if (k == 1) begin
            ss = 1'b1; pr = PRNG;
        end else if (k <= 36) begin
            j = k - 2; r = 1 + j / 7; c = j % 7; pr = PRNG && (c == 0);
        end else if (k <= 50) begin
            r = 6; c = k - 37; pr = PRNG && (c == 0);
        end else if (k <= 85) begin
            j = k - 51; r = 7 + j / 7; c = j % 7; sh = 1'b1; pr = PRNG && (c == 0);
        end else begin
            d = 1'b1; sh = 1'b1; se = 1'b1; r = 12;
        end
        return {b, d, ss, sh, se, pr, 4'(r), 4'(c)};
    endfunction

    task automatic push(input int t, input logic [13:0] v, input logic [13:0] m);
        exp_t e;
        e.t = t; e.v = v; e.m = m;
        q.push_back(e);
    endtask

    task automatic push_run(input int base, input int last);
        for (int k = 1; k <= last; k++) begin
            push(base + k, exp_v(k), (k == 86) ? NO_C : FULL);
        end
    endtask

    task automatic wait_to(input int t);
        while (tcyc < t) @(negedge clk);
    endtask

    // Monitor: compare the due expectation, flag any unexpected done.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].t == tcyc) begin
            e = q.pop_front();
            chk("main", tcyc, {busy, done, sel_start, sel_half, sel_end, prng_step, round, cyc},
                e.v, e.m);
        end else if (done === 1'b1) begin
            chk("spurious_done", tcyc, {13'h0, done}, 14'h0, FULL);
        end
    end

    // Small configuration (N=2, C=1, M=1): done in cycle 7.
    task automatic small_check(input int base);
        logic [13:0] tbl [8];
        logic [13:0] w;
        tbl[0] = 14'h2800; tbl[1] = 14'h2010; tbl[2] = 14'h2020; tbl[3] = 14'h2030;
        tbl[4] = 14'h2440; tbl[5] = 14'h2450; tbl[6] = 14'h3660; tbl[7] = 14'h0000;
        for (int k = 1; k <= 8; k++) begin
            wait_to(base + k);
            w = tbl[k-1];
            if (PRNG && k <= 6) w = w | 14'h0100;
            chk("small", k, {busy2, done2, sel_start2, sel_half2, sel_end2, prng_step2, round2, cyc2},
                w, FULL);
        end
    endtask

    initial begin
        int b;
        reset = 1'b1;
        start = 1'b1;
        // Reset with start high: reset must win.
        for (int t = 1; t <= 4; t++) push(t, 14'h0, FULL);
        wait_to(3);
        reset = 1'b0;
        start = 1'b0;

        // Single start pulse, defaults.
        b = 5;
        wait_to(b);
        start = 1'b1;
        push_run(b, 86);
        push(b + 87, 14'h0, NO_RC);
        fork
            begin
                wait_to(b + 1);
                start = 1'b0;
                wait_to(b + 88);
            end
            small_check(b);
        join

        // Abort with reset in cycle 40 (MID).
        b = 93;
        wait_to(b);
        start = 1'b1;
        push_run(b, 40);
        for (int k = 41; k <= 140; k++) push(b + k, 14'h0, FULL);
        wait_to(b + 1);
        start = 1'b0;
        wait_to(b + 40);
        reset = 1'b1;
        wait_to(b + 41);
        reset = 1'b0;
        wait_to(b + 141);

        // Start held high: back-to-back runs, done at 86 and 173.
        b = 234;
        wait_to(b);
        start = 1'b1;
        push_run(b, 86);
        push(b + 87, 14'h0, NO_RC);
        push_run(b + 87, 86);
        push(b + 174, 14'h0, NO_RC);
        wait_to(b + 173);
        start = 1'b0;
        wait_to(b + 176);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
